axi_txn_guard: RTL and testbench

//  Generalised AXI transaction watchdog, successor to the write-only guard. It serves either the write (AW->B)
//  or the read (AR->R last) direction, selected by parameter, and tracks up to NumSlots outstanding transactions

---
 rtl/axi_txn_guard.sv | 214 +++++++++++++++++++++
 tb/tb_axi_txn_guard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/axi_txn_guard.sv
// axi_txn_guard: passive AXI transaction watchdog for one direction.
// ReadMode=0 tracks AW->B, ReadMode=1 tracks AR->R(last).
// Up to NumSlots outstanding transactions are kept, with per-ID ordering,
// length-scaled timeout budgets, back-pressure when full and latency reporting.
// Ports:
//   clk_i, rst_i (sync, active-high), enable_i
//   req_*          observed AW/AR channel (valid, ready, id, addr, len)
//   rsp_*          observed B/R channel (valid, ready, id, last)
//   budget_base_i  fixed budget part; budget_beat_i per-beat budget
//   reset_clear_i  clears the latched reset request
//   stall_o        all slots busy (combinational from slot registers)
//   irq_o, reset_req_o, irq_cause_o, irq_id_o, irq_addr_o  error report
//   latency_o, latency_valid_o  latency of the last retired transaction
//   outstanding_o  busy slot count
module axi_txn_guard #(
  parameter bit          ReadMode  = 1'b0,
  parameter int unsigned NumSlots  = 8,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          req_valid_i,
  input  logic                          req_ready_i,
  input  logic [IdWidth-1:0]            req_id_i,
  input  logic [AddrWidth-1:0]          req_addr_i,
  input  logic [LenWidth-1:0]           req_len_i,
  input  logic                          rsp_valid_i,
  input  logic                          rsp_ready_i,
  input  logic [IdWidth-1:0]            rsp_id_i,
  input  logic                          rsp_last_i,
  input  logic [CntWidth-1:0]           budget_base_i,
  input  logic [CntWidth-1:0]           budget_beat_i,
  input  logic                          reset_clear_i,
  output logic                          stall_o,
  output logic                          irq_o,
  output logic                          reset_req_o,
  output logic [1:0]                    irq_cause_o,
  output logic [IdWidth-1:0]            irq_id_o,
  output logic [AddrWidth-1:0]          irq_addr_o,
  output logic [CntWidth-1:0]           latency_o,
  output logic                          latency_valid_o,
  output logic [$clog2(NumSlots+1)-1:0] outstanding_o
);

  localparam int unsigned IdxW  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int unsigned OutW  = $clog2(NumSlots + 1);
  localparam int unsigned WideW = CntWidth + LenWidth + 2;

  localparam logic [1:0] CauseNone     = 2'd0;
  localparam logic [1:0] CauseTimeout  = 2'd1;
  localparam logic [1:0] CauseUnwanted = 2'd2;
  localparam logic [1:0] CauseOverflow = 2'd3;

  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [CntWidth-1:0]  cnt;
    logic [CntWidth-1:0]  budget;
    logic [IdxW-1:0]      seq;     // order among same-ID slots, 0 = oldest
  } slot_t;

  slot_t               slot_q [NumSlots];
  slot_t               slot_d [NumSlots];
  logic [NumSlots-1:0] busy_q;
  logic [NumSlots-1:0] busy_d;

  logic                 req_hs, rsp_hs, active;
  logic                 ret_hit, free_hit, to_hit;
  logic [IdxW-1:0]      ret_idx, free_idx, to_idx;
  logic                 do_retire, do_alloc;
  logic                 overflow, unwanted, timeout, err;
  logic [IdxW-1:0]      new_seq;
  logic [1:0]           cause_d;
  logic [IdWidth-1:0]   err_id_d;
  logic [AddrWidth-1:0] err_addr_d;
  logic [CntWidth-1:0]  lat_d;
  logic [OutW-1:0]      busy_cnt;

  // Budget = base + beat*(len+1), saturated to the counter width.
  function automatic logic [CntWidth-1:0] calc_budget(
    input logic [CntWidth-1:0] base,
    input logic [CntWidth-1:0] beat,
    input logic [LenWidth-1:0] len
  );
    logic [WideW-1:0] sum;
    sum = WideW'(base) + WideW'(beat) * (WideW'(len) + WideW'(1));
    if (|sum[WideW-1:CntWidth]) return CntMax;
    return sum[CntWidth-1:0];
  endfunction

  assign stall_o = &busy_q;

  // Slot bookkeeping and error detection.
  always_comb begin
    busy_d     = busy_q;
    for (int unsigned i = 0; i < NumSlots; i++) slot_d[i] = slot_q[i];
    ret_hit    = 1'b0;
    ret_idx    = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    to_hit     = 1'b0;
    to_idx     = '0;
    new_seq    = '0;
    busy_cnt   = '0;
    cause_d    = CauseNone;
    err_id_d   = '0;
    err_addr_d = '0;

    req_hs = req_valid_i & req_ready_i;
    rsp_hs = rsp_valid_i & rsp_ready_i & (!ReadMode || rsp_last_i);
    active = enable_i & ~reset_req_o;

    for (int unsigned i = 0; i < NumSlots; i++) begin
      if (busy_q[i]) busy_cnt = busy_cnt + OutW'(1);
      if (!ret_hit && busy_q[i] && slot_q[i].id == rsp_id_i && slot_q[i].seq == '0) begin
        ret_hit = 1'b1;
        ret_idx = IdxW'(i);
      end
      if (!free_hit && !busy_q[i]) begin
        free_hit = 1'b1;
        free_idx = IdxW'(i);
      end
      if (!to_hit && busy_q[i] && slot_q[i].cnt >= slot_q[i].budget) begin
        to_hit = 1'b1;
        to_idx = IdxW'(i);
      end
    end

    do_retire = active & rsp_hs & ret_hit;
    unwanted  = active & rsp_hs & ~ret_hit;
    // A slot freed this cycle is not reusable until the next one.
    overflow  = active & req_hs & stall_o;
    do_alloc  = active & req_hs & free_hit;
    timeout   = active & to_hit;
    err       = overflow | unwanted | timeout;

    lat_d = (slot_q[ret_idx].cnt == CntMax) ? CntMax : slot_q[ret_idx].cnt + CntWidth'(1);

    for (int unsigned i = 0; i < NumSlots; i++) begin
      if (enable_i && busy_q[i] && slot_q[i].cnt != CntMax)
        slot_d[i].cnt = slot_q[i].cnt + CntWidth'(1);
      if (do_retire && busy_q[i] && IdxW'(i) != ret_idx && slot_q[i].id == rsp_id_i)
        slot_d[i].seq = slot_q[i].seq - IdxW'(1);
      if (busy_q[i] && slot_q[i].id == req_id_i && !(do_retire && IdxW'(i) == ret_idx))
        new_seq = new_seq + IdxW'(1);
    end

    if (do_retire) busy_d[ret_idx] = 1'b0;

    if (do_alloc) begin
      busy_d[free_idx]        = 1'b1;
      slot_d[free_idx].id     = req_id_i;
      slot_d[free_idx].addr   = req_addr_i;
      slot_d[free_idx].cnt    = '0;
      slot_d[free_idx].budget = calc_budget(budget_base_i, budget_beat_i, req_len_i);
      slot_d[free_idx].seq    = new_seq;
    end

    if (overflow) begin
      cause_d    = CauseOverflow;
      err_id_d   = req_id_i;
      err_addr_d = req_addr_i;
    end else if (unwanted) begin
      cause_d    = CauseUnwanted;
      err_id_d   = rsp_id_i;
    end else if (timeout) begin
      cause_d    = CauseTimeout;
      err_id_d   = slot_q[to_idx].id;
      err_addr_d = slot_q[to_idx].addr;
    end

    // Every slot is dropped on the latch edge and stays empty while latched.
    if (err || reset_req_o) busy_d = '0;
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q          <= '0;
      for (int unsigned i = 0; i < NumSlots; i++) slot_q[i] <= '0;
      irq_o           <= 1'b0;
      reset_req_o     <= 1'b0;
      irq_cause_o     <= CauseNone;
      irq_id_o        <= '0;
      irq_addr_o      <= '0;
      latency_o       <= '0;
      latency_valid_o <= 1'b0;
      outstanding_o   <= '0;
    end else begin
      busy_q          <= busy_d;
      for (int unsigned i = 0; i < NumSlots; i++) slot_q[i] <= slot_d[i];
      irq_o           <= err;
      latency_valid_o <= do_retire;
      outstanding_o   <= busy_cnt;
      if (do_retire) latency_o <= lat_d;
      if (err) begin
        reset_req_o <= 1'b1;
        irq_cause_o <= cause_d;
        irq_id_o    <= err_id_d;
        irq_addr_o  <= err_addr_d;
      end else if (reset_clear_i) begin
        reset_req_o <= 1'b0;
        irq_cause_o <= CauseNone;
      end
    end
  end

endmodule

// File: tb/tb_axi_txn_guard.sv
// Bench for axi_txn_guard: a vector table on a write-mode 8-slot instance,
// plus hand sequences on a 2-slot instance and a read-mode 4-bit-counter instance.
module tb_axi_txn_guard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, rq_v, rq_r, rs_v, rs_r, rs_last, clr;
  logic [3:0]  rq_id, rs_id;
  logic [63:0] rq_addr;
  logic [7:0]  rq_len;
  logic [15:0] base, beat;

  // write mode, 8 slots
  logic a_stall, a_irq, a_rreq, a_latv;
  logic [1:0] a_cause; logic [3:0] a_iid; logic [63:0] a_iaddr; logic [15:0] a_lat; logic [3:0] a_outs;
  // write mode, 2 slots
  logic b_stall, b_irq, b_rreq, b_latv;
  logic [1:0] b_cause; logic [3:0] b_iid; logic [63:0] b_iaddr; logic [15:0] b_lat; logic [1:0] b_outs;
  // read mode, 4 slots, 4-bit counters, 32-bit addresses
  logic c_stall, c_irq, c_rreq, c_latv;
  logic [1:0] c_cause; logic [3:0] c_iid; logic [31:0] c_iaddr; logic [3:0] c_lat; logic [2:0] c_outs;

  axi_txn_guard #(.ReadMode(1'b0), .NumSlots(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .req_valid_i(rq_v), .req_ready_i(rq_r), .req_id_i(rq_id), .req_addr_i(rq_addr), .req_len_i(rq_len),
    .rsp_valid_i(rs_v), .rsp_ready_i(rs_r), .rsp_id_i(rs_id), .rsp_last_i(rs_last),
    .budget_base_i(base), .budget_beat_i(beat), .reset_clear_i(clr),
    .stall_o(a_stall), .irq_o(a_irq), .reset_req_o(a_rreq), .irq_cause_o(a_cause),
    .irq_id_o(a_iid), .irq_addr_o(a_iaddr), .latency_o(a_lat), .latency_valid_o(a_latv),
    .outstanding_o(a_outs));

  axi_txn_guard #(.ReadMode(1'b0), .NumSlots(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .req_valid_i(rq_v), .req_ready_i(rq_r), .req_id_i(rq_id), .req_addr_i(rq_addr), .req_len_i(rq_len),
    .rsp_valid_i(rs_v), .rsp_ready_i(rs_r), .rsp_id_i(rs_id), .rsp_last_i(rs_last),
    .budget_base_i(base), .budget_beat_i(beat), .reset_clear_i(clr),
    .stall_o(b_stall), .irq_o(b_irq), .reset_req_o(b_rreq), .irq_cause_o(b_cause),
    .irq_id_o(b_iid), .irq_addr_o(b_iaddr), .latency_o(b_lat), .latency_valid_o(b_latv),
    .outstanding_o(b_outs));

  axi_txn_guard #(.ReadMode(1'b1), .NumSlots(4), .AddrWidth(32), .CntWidth(4)) u_rd (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .req_valid_i(rq_v), .req_ready_i(rq_r), .req_id_i(rq_id), .req_addr_i(rq_addr[31:0]), .req_len_i(rq_len),
    .rsp_valid_i(rs_v), .rsp_ready_i(rs_r), .rsp_id_i(rs_id), .rsp_last_i(rs_last),
    .budget_base_i(base[3:0]), .budget_beat_i(beat[3:0]), .reset_clear_i(clr),
    .stall_o(c_stall), .irq_o(c_irq), .reset_req_o(c_rreq), .irq_cause_o(c_cause),
    .irq_id_o(c_iid), .irq_addr_o(c_iaddr), .latency_o(c_lat), .latency_valid_o(c_latv),
    .outstanding_o(c_outs));

  typedef struct {
    logic rst, en, rqv; logic [3:0] rqid; logic [63:0] rqaddr; logic [7:0] rqlen;
    logic rsv; logic [3:0] rsid; logic [15:0] base, beat; logic clr;
    logic stall, irq, rreq; logic [1:0] cause; logic [3:0] iid; logic [63:0] iaddr;
    logic [15:0] lat; logic latv; logic [3:0] outs;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(
    input logic i_rst, input logic i_en, input logic i_rqv, input logic [3:0] i_rqid,
    input logic [63:0] i_rqaddr, input logic [7:0] i_rqlen, input logic i_rsv, input logic [3:0] i_rsid,
    input logic [15:0] i_base, input logic [15:0] i_beat, input logic i_clr,
    input logic e_stall, input logic e_irq, input logic e_rreq, input logic [1:0] e_cause,
    input logic [3:0] e_iid, input logic [63:0] e_iaddr, input logic [15:0] e_lat,
    input logic e_latv, input logic [3:0] e_outs);
    vecs.push_back('{i_rst, i_en, i_rqv, i_rqid, i_rqaddr, i_rqlen, i_rsv, i_rsid, i_base, i_beat, i_clr,
                     e_stall, e_irq, e_rreq, e_cause, e_iid, e_iaddr, e_lat, e_latv, e_outs});
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v_rq, input logic [3:0] v_rqid, input logic [63:0] v_addr,
                       input logic [7:0] v_len, input logic v_rs, input logic [3:0] v_rsid,
                       input logic v_last);
    rq_v = v_rq; rq_r = v_rq; rq_id = v_rqid; rq_addr = v_addr; rq_len = v_len;
    rs_v = v_rs; rs_r = v_rs; rs_id = v_rsid; rs_last = v_last;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; base = '0; beat = '0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // rst en rqv id addr len rsv id base beat clr | stall irq rreq cause iid iaddr lat latv outs
    add(1,0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0,0,0);
    // single write, latency 6, rsp_last ignored in write mode
    add(0,1,1,3,'h1000,3,0,0,10,2,0,    0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) add(0,1,0,0,0,0,0,0,10,2,0, 0,0,0,0,0,0,0,0,1);
    add(0,1,0,0,0,0,1,3,10,2,0,         0,0,0,0,0,0,6,1,1);
    add(0,1,0,0,0,0,0,0,10,2,0,         0,0,0,0,0,0,6,0,0);
    // same-ID ordering: the older slot retires first
    add(0,1,1,2,'h100,0,0,0,100,0,0,    0,0,0,0,0,0,6,0,0);
    add(0,1,1,2,'h200,0,0,0,100,0,0,    0,0,0,0,0,0,6,0,1);
    add(0,1,0,0,0,0,1,2,100,0,0,        0,0,0,0,0,0,2,1,2);
    add(0,1,0,0,0,0,0,0,100,0,0,        0,0,0,0,0,0,2,0,1);
    add(0,1,0,0,0,0,1,2,100,0,0,        0,0,0,0,0,0,3,1,1);
    add(0,1,0,0,0,0,0,0,100,0,0,        0,0,0,0,0,0,3,0,0);
    // unwanted response, then clear
    add(0,1,0,0,0,0,1,7,100,0,0,        0,1,1,2,7,0,3,0,0);
    add(0,1,0,0,0,0,0,0,100,0,0,        0,0,1,2,7,0,3,0,0);
    add(0,1,0,0,0,0,0,0,100,0,1,        0,0,0,0,7,0,3,0,0);
    // timeout with budget 4
    add(0,1,1,1,'hABC0,0,0,0,4,0,0,     0,0,0,0,7,0,3,0,0);
    for (int i = 0; i < 4; i++) add(0,1,0,0,0,0,0,0,4,0,0, 0,0,0,0,7,0,3,0,1);
    add(0,1,0,0,0,0,0,0,4,0,0,          0,1,1,1,1,'hABC0,3,0,1);
    add(0,1,0,0,0,0,0,0,4,0,0,          0,0,1,1,1,'hABC0,3,0,0);
    // no allocation while latched, then clear
    add(0,1,1,5,'h500,0,0,0,4,0,0,      0,0,1,1,1,'hABC0,3,0,0);
    add(0,1,0,0,0,0,0,0,4,0,0,          0,0,1,1,1,'hABC0,3,0,0);
    add(0,1,0,0,0,0,0,0,4,0,1,          0,0,0,0,1,'hABC0,3,0,0);
    // disabled: neither alloc nor unwanted
    add(0,0,1,4,'h400,0,0,0,4,0,0,      0,0,0,0,1,'hABC0,3,0,0);
    add(0,0,0,0,0,0,1,9,4,0,0,          0,0,0,0,1,'hABC0,3,0,0);
    add(0,1,0,0,0,0,0,0,4,0,0,          0,0,0,0,1,'hABC0,3,0,0);
    // length-scaled budget 1+1*2 = 3
    add(0,1,1,6,'h40,1,0,0,1,1,0,       0,0,0,0,1,'hABC0,3,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0,0,0,0,1,1,0, 0,0,0,0,1,'hABC0,3,0,1);
    add(0,1,0,0,0,0,0,0,1,1,0,          0,1,1,1,6,'h40,3,0,1);
    add(0,1,0,0,0,0,0,0,1,1,1,          0,0,0,0,6,'h40,3,0,0);

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; en = vecs[k].en; clr = vecs[k].clr;
      base = vecs[k].base; beat = vecs[k].beat;
      drive(vecs[k].rqv, vecs[k].rqid, vecs[k].rqaddr, vecs[k].rqlen, vecs[k].rsv, vecs[k].rsid, 1'b0);
      step();
      chk($sformatf("vec%0d", k),
          {a_stall, a_irq, a_rreq, a_cause, a_iid, a_iaddr, a_lat, a_latv, a_outs},
          {vecs[k].stall, vecs[k].irq, vecs[k].rreq, vecs[k].cause, vecs[k].iid,
           vecs[k].iaddr, vecs[k].lat, vecs[k].latv, vecs[k].outs});
    end

    // Two-slot instance: full, then alloc+retire in the same cycle is an overflow
    rst = 1'b1; en = 1'b1; clr = 1'b0; base = 16'd100; beat = 16'd0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    chk("b_reset", {b_stall, b_rreq, b_outs}, '0);
    drive(1, 0, 64'h10, 0, 0, 0, 0);
    step();
    chk("b_one_busy", b_stall, 0);
    drive(1, 1, 64'h20, 0, 0, 0, 0);
    step();
    chk("b_full_stall", b_stall, 1);
    drive(1, 2, 64'h300, 0, 1, 0, 0);
    step();
    chk("b_overflow", {b_irq, b_rreq, b_cause, b_iid, b_iaddr}, {1'b1, 1'b1, 2'd3, 4'd2, 64'h300});
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("b_flushed", {b_stall, b_irq, b_rreq}, {1'b0, 1'b0, 1'b1});

    // Read instance: retire only on the last beat; 12+1*4 saturates to 15
    rst = 1'b1; base = 16'd12; beat = 16'd1;
    step();
    rst = 1'b0;
    chk("c_reset", {c_stall, c_rreq, c_outs}, '0);
    drive(1, 0, 64'h80, 3, 0, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1, 0, (k == 3));
      step();
      if (k < 3) chk($sformatf("c_beat%0d", k), {c_latv, c_irq, c_outs}, {1'b0, 1'b0, 3'd1});
      else       chk("c_last_beat", {c_latv, c_lat, c_irq, c_outs}, {1'b1, 4'd4, 1'b0, 3'd1});
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("c_retired", {c_outs, c_irq, c_rreq}, '0);
    drive(1, 1, 64'h90, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("c_inflight", c_outs, 3'd1);
    rst = 1'b1;
    step();
    chk("c_midflight_reset",
        {c_stall, c_irq, c_rreq, c_cause, c_iid, c_iaddr, c_lat, c_latv, c_outs}, '0);
    chk("a_reset", {a_stall, a_irq, a_rreq, a_cause, a_iid, a_iaddr, a_lat, a_latv, a_outs}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
